// File: rtl/aurora_tx_arbiter.sv
// ---------------------------------------------------------------------------
// aurora_tx_arbiter
//
// Packet-level round-robin arbiter driving the 2-bit source select of the
// 4-channel Aurora TX AXI-Stream mux. A channel keeps its grant until its
// tlast beat is accepted, so packets are never interleaved on the link.
// After every packet (or watchdog release) the arbiter idles for GAP_CYCLES
// before scanning again. A watchdog frees a grant whose source stops
// delivering beats mid-packet. Per-channel counters track completed packets.
//
// Ports:
//   clk            in   system clock
//   rstn           in   asynchronous active-low reset
//   ch_en          in   per-channel arbitration enable
//   axis_s_tvalid  in   source tvalid, channel i = bit i
//   axis_s_tlast   in   source tlast, channel i = bit i
//   axis_m_tready  in   tready at the mux output
//   axis_s_sel     out  registered select to the mux
//   grant_active   out  high while a channel holds the grant
//   timeout_err    out  one-cycle pulse when the watchdog releases a grant
//   timeout_ch     out  channel released by the last watchdog event
//   pkt_cnt        out  completed-packet counts, channel i at [i*CNTW +: CNTW]
// ---------------------------------------------------------------------------
module aurora_tx_arbiter #(
  parameter int unsigned ETHCOUNT   = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNTW       = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ETHCOUNT-1:0]      ch_en,
  input  logic [ETHCOUNT-1:0]      axis_s_tvalid,
  input  logic [ETHCOUNT-1:0]      axis_s_tlast,
  input  logic                     axis_m_tready,
  output logic [1:0]               axis_s_sel,
  output logic                     grant_active,
  output logic                     timeout_err,
  output logic [1:0]               timeout_ch,
  output logic [ETHCOUNT*CNTW-1:0] pkt_cnt
);

  localparam int unsigned SELW   = 2;
  localparam int unsigned GAPW   = 4;
  localparam int unsigned STALLW = $clog2(TIMEOUT) + 1;

  localparam logic [GAPW-1:0]   GAP_LAST   = GAPW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [STALLW-1:0] STALL_LAST = STALLW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [STALLW-1:0] STALL_MAX  = {STALLW{1'b1}};
  localparam logic              WDOG_EN    = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // State entered after a packet ends; the gap phase is skipped when it is empty.
  localparam state_t S_DONE = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t                        r_state;
  logic [SELW-1:0]               r_sel;
  logic [SELW-1:0]               r_last_ch;
  logic [SELW-1:0]               r_timeout_ch;
  logic                          r_grant_active;
  logic                          r_timeout_err;
  logic [GAPW-1:0]               r_gap_cnt;
  logic [STALLW-1:0]             r_stall_cnt;
  logic [ETHCOUNT-1:0][CNTW-1:0] r_pkt_cnt;

  logic [ETHCOUNT-1:0] w_req;
  logic [SELW-1:0]     w_scan_idx;
  logic [SELW-1:0]     w_winner;
  logic                w_any_req;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_expire;

  assign w_req       = axis_s_tvalid & ch_en;
  assign w_beat      = axis_s_tvalid[r_sel] & axis_m_tready;
  assign w_last_beat = w_beat & axis_s_tlast[r_sel];
  // Watchdog fires on the TIMEOUT-th consecutive beat-less cycle of a grant.
  assign w_expire    = WDOG_EN & ~w_beat & (r_stall_cnt == STALL_LAST);

  // Round-robin scan starting just after the last served channel. Walking the
  // offsets from farthest to nearest lets the nearest requester win; offset 4
  // is the last served channel itself, which therefore has lowest priority.
  always_comb begin
    w_scan_idx = '0;
    w_winner   = r_sel;
    w_any_req  = 1'b0;
    for (int k = int'(ETHCOUNT); k >= 1; k--) begin
      w_scan_idx = r_last_ch + SELW'(k);
      if (w_req[w_scan_idx]) begin
        w_winner  = w_scan_idx;
        w_any_req = 1'b1;
      end
    end
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_sel          <= '0;
      r_last_ch      <= SELW'(3);
      r_grant_active <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_timeout_ch   <= '0;
      r_gap_cnt      <= '0;
      r_stall_cnt    <= '0;
      r_pkt_cnt      <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel          <= w_winner;
            r_stall_cnt    <= '0;
            r_grant_active <= 1'b1;
            r_state        <= S_GRANT;
          end
        end

        S_GRANT: begin
          // A tlast beat wins over a simultaneous watchdog expiry.
          if (w_last_beat) begin
            r_pkt_cnt[r_sel] <= r_pkt_cnt[r_sel] + CNTW'(1);
            r_last_ch        <= r_sel;
            r_gap_cnt        <= '0;
            r_grant_active   <= 1'b0;
            r_state          <= S_DONE;
          end else if (w_beat) begin
            r_stall_cnt <= '0;
          end else if (w_expire) begin
            r_timeout_err  <= 1'b1;
            r_timeout_ch   <= r_sel;
            r_last_ch      <= r_sel;
            r_gap_cnt      <= '0;
            r_grant_active <= 1'b0;
            r_state        <= S_DONE;
          end else if (r_stall_cnt != STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + STALLW'(1);
          end
        end

        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + GAPW'(1);
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_grant_active <= 1'b0;
        end
      endcase
    end
  end

  assign axis_s_sel   = r_sel;
  assign grant_active = r_grant_active;
  assign timeout_err  = r_timeout_err;
  assign timeout_ch   = r_timeout_ch;
  assign pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aurora_tx_arbiter
//
// Bench for aurora_tx_arbiter (GAP_CYCLES=1, TIMEOUT=16, CNTW=4). Each
// channel is a packet source with a queue of packets; a behavioural model
// of the arbitration rules runs alongside the DUT and every output is
// compared against it on each falling edge, plus directed literal checks.
// ---------------------------------------------------------------------------
module tb_aurora_tx_arbiter;

  localparam int unsigned P_GAP  = 1;
  localparam int unsigned P_TO   = 16;
  localparam int unsigned P_CNTW = 4;
  localparam int          NCH    = 4;

  logic        clk;
  logic        rstn;
  logic [3:0]  ch_en;
  logic [3:0]  tvalid;
  logic [3:0]  tlast;
  logic        tready;
  logic [1:0]  sel;
  logic        ga;
  logic        terr;
  logic [1:0]  tch;
  logic [15:0] pcnt;

  aurora_tx_arbiter #(
    .ETHCOUNT  (4),
    .GAP_CYCLES(P_GAP),
    .TIMEOUT   (P_TO),
    .CNTW      (P_CNTW)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .ch_en        (ch_en),
    .axis_s_tvalid(tvalid),
    .axis_s_tlast (tlast),
    .axis_m_tready(tready),
    .axis_s_sel   (sel),
    .grant_active (ga),
    .timeout_err  (terr),
    .timeout_ch   (tch),
    .pkt_cnt      (pcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;

  // Packet sources: beats left in current packet, queued packets, stall mask.
  int rem[NCH];
  int pend_n[NCH];
  int pend_len[NCH];
  bit hold[NCH];

  // Model: who owns the link, remaining gap cycles, beat-less cycles so far.
  bit m_busy;
  int m_owner;
  int m_gap;
  int m_quiet;
  int m_last;
  int m_sel;
  int m_cnt[NCH];
  bit m_err;
  int m_err_ch;

  int ord[$];
  bit prev_ga;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_gap = 0; m_quiet = 0;
    m_last = 3; m_sel = 0; m_err = 0; m_err_ch = 0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endfunction

  function automatic void refill();
    for (int i = 0; i < NCH; i++) begin
      if (rem[i] == 0 && pend_n[i] > 0) begin
        rem[i] = pend_len[i];
        pend_n[i]--;
      end
    end
  endfunction

  function automatic void end_grant(input int o);
    m_busy = 0;
    m_last = o;
    m_gap  = P_GAP;
  endfunction

  function automatic void model_step();
    bit beat;
    bit found;
    int o;
    int c;
    m_err = 0;
    if (m_busy) begin
      o = m_owner;
      beat = tvalid[o] && tready;
      if (beat && tlast[o]) begin
        m_cnt[o] = (m_cnt[o] + 1) % (1 << P_CNTW);
        end_grant(o);
      end else if (beat) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (P_TO > 0 && m_quiet >= P_TO) begin
          m_err = 1;
          m_err_ch = o;
          end_grant(o);
        end
      end
      if (beat) rem[o]--;
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 0;
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (!found && tvalid[c] && ch_en[c]) begin
          found = 1; m_owner = c; m_sel = c; m_busy = 1; m_quiet = 0;
        end
      end
    end
    refill();
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic [15:0] exp_cnt;
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) exp_cnt[i*4 +: 4] = 4'(m_cnt[i]);
      chk("sel", 32'(sel), m_sel);
      chk("grant_active", 32'(ga), 32'(m_busy));
      chk("timeout_err", 32'(terr), 32'(m_err));
      chk("timeout_ch", 32'(tch), m_err_ch);
      chk("pkt_cnt", 32'(pcnt), 32'(exp_cnt));
    end
  end

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      tvalid[i] = (rem[i] > 0) && !hold[i];
      tlast[i]  = (rem[i] == 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input int ch, input int len, input int n);
    pend_len[ch] = len;
    pend_n[ch]   = pend_n[ch] + n;
    refill();
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NCH; i++) begin
      rem[i] = 0; pend_n[i] = 0; pend_len[i] = 0; hold[i] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ch_en = 4'hF;
    tready = 1'b1;
    clear_src();
    cyc();
    cyc();
    rstn = 1'b1;
    ord.delete();
    prev_ga = 1'b0;
  endtask

  task automatic note_grant();
    if (ga && !prev_ga) ord.push_back(int'(sel));
    prev_ga = ga;
  endtask

  task automatic chk_order(input string nm, input int exp[], input int n);
    chk({nm, "_len"}, ord.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ord.size()) chk(nm, ord[i], exp[i]);
    end
  endtask

  int exp_rr[]  = '{0, 1, 2, 3, 0, 1};
  int exp_en[]  = '{1, 3, 1, 3, 3};
  int ga_cycles;

  initial begin
    rstn = 1'b0;
    ch_en = 4'hF;
    tready = 1'b1;
    clear_src();
    model_reset();
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(ga), 0);
    chk("rst_terr", 32'(terr), 0);
    chk("rst_tch", 32'(tch), 0);
    chk("rst_cnt", 32'(pcnt), 0);

    // Single 3-beat packet on channel 1.
    do_reset();
    push(1, 3, 1);
    ga_cycles = 0;
    cyc();
    chk("t1_sel", 32'(sel), 1);
    for (int c = 0; c < 6; c++) begin
      if (ga) ga_cycles++;
      if (c == 3) begin
        chk("t1_ga_end", 32'(ga), 0);
        chk("t1_cnt", 32'(pcnt), 32'h0010);
      end
      cyc();
    end
    chk("t1_ga_cycles", ga_cycles, 3);

    // All four channels continuously requesting, 2-beat packets.
    do_reset();
    for (int i = 0; i < NCH; i++) push(i, 2, 3);
    for (int c = 1; c <= 24; c++) begin
      cyc();
      note_grant();
      if (c == 16) chk("t2_cnt", 32'(pcnt), 32'h1111);
    end
    chk_order("t2_order", exp_rr, 6);

    // Channel 2 with tready toggling on a 4-beat packet.
    do_reset();
    tready = 1'b0;
    push(2, 4, 1);
    cyc();
    chk("t3_sel", 32'(sel), 2);
    ga_cycles = 1;
    for (int k = 0; k < 8; k++) begin
      tready = (k % 2 == 1);
      cyc();
      if (ga) ga_cycles++;
      if (k == 6) chk("t3_cnt_pend", 32'(pcnt), 0);
    end
    chk("t3_cnt", 32'(pcnt), 32'h0100);
    chk("t3_ga_cycles", ga_cycles, 8);
    tready = 1'b1;

    // Watchdog: channel 0 stops after its first beat.
    do_reset();
    push(0, 4, 1);
    push(1, 2, 1);
    cyc();
    chk("t4_sel0", 32'(sel), 0);
    cyc();
    hold[0] = 1;
    drive();
    for (int c = 0; c < 15; c++) cyc();
    chk("t4_terr_early", 32'(terr), 0);
    cyc();
    chk("t4_terr", 32'(terr), 1);
    chk("t4_tch", 32'(tch), 0);
    chk("t4_cnt", 32'(pcnt), 0);
    cyc();
    chk("t4_terr_pulse", 32'(terr), 0);
    cyc();
    chk("t4_next_sel", 32'(sel), 1);
    chk("t4_next_ga", 32'(ga), 1);

    // Only channels 1 and 3 enabled; ch_en[1] dropped mid-packet.
    do_reset();
    ch_en = 4'b1010;
    for (int i = 0; i < NCH; i++) push(i, 2, 3);
    for (int c = 1; c <= 17; c++) begin
      cyc();
      note_grant();
      if (c == 10) ch_en = 4'b1000;
      if (c == 11) chk("t5_cnt_mid", 32'(pcnt), 32'h1020);
      if (c == 15) chk("t5_cnt", 32'(pcnt), 32'h2020);
    end
    chk_order("t5_order", exp_en, 5);

    // Asynchronous reset in the middle of a channel-3 packet.
    do_reset();
    push(0, 2, 1);
    push(3, 4, 1);
    for (int c = 0; c < 6; c++) cyc();
    chk("t6_pre_sel", 32'(sel), 3);
    chk("t6_pre_cnt", 32'(pcnt), 32'h0001);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_sel", 32'(sel), 0);
    chk("t6_async_ga", 32'(ga), 0);
    chk("t6_async_cnt", 32'(pcnt), 0);
    clear_src();
    cyc();
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < NCH; i++) push(i, 2, 1);
    cyc();
    chk("t6_first_sel", 32'(sel), 0);
    chk("t6_first_ga", 32'(ga), 1);

    // Counter wrap: 17 one-beat packets on channel 0 with a 4-bit counter.
    do_reset();
    push(0, 1, 17);
    for (int c = 1; c <= 60; c++) begin
      cyc();
      if (c == 47) chk("t7_cnt_wrap0", 32'(pcnt), 0);
    end
    chk("t7_cnt", 32'(pcnt), 32'h0001);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
